// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART 8N1-style receiver with mid-bit sampling and framing-error detection
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state_q;
    logic                   rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q, data_q;
    logic                   valid_q, frame_err_q;
    logic                   tick;

    // Synchroniser idles high so a reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= cnt_d;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) state_q <= START;
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) state_q <= STOP;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch the next start edge.
                    if (tick) begin
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    cnt_q <= '0;
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard-checked directed bench for uart_rx
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [DB-1:0] data;
    logic          valid, frame_err, busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_err;
        logic [DB-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vt[$];
    int   n_checks = 0, n_fail = 0;
    int   cyc = 0;
    int   valid_cnt = 0, ferr_cnt = 0, busy_run = 0, busy_max = 0;
    int   t0, t1, lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (busy) begin
                busy_run++;
                if (busy_run > busy_max) busy_max = busy_run;
            end else begin
                busy_run = 0;
            end
            if (valid || frame_err) begin
                exp_t e;
                check("pulse_excl", 32'(valid & frame_err), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {22'd0, valid, frame_err, data}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'(frame_err), 32'(e.is_err));
                    check("pulse_data", 32'(data), 32'(e.data));
                end
                if (valid) begin
                    valid_cnt++;
                    vt.push_back(cyc);
                end
                if (frame_err) ferr_cnt++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ph is the bit period in half-clock units, so 31/33 give 15.5/16.5 clk bits.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit, input int ph, output int ts);
        logic [DB+1:0] f;
        f  = {stop_bit, b, 1'b0};
        ts = cyc;
        for (int k = 0; k < DB + 2; k++) begin
            rx = f[k];
            idle(((k + 1) * ph) / 2 - (k * ph) / 2);
        end
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b0;
        idle(3);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        idle(10);

        exp_q.push_back({1'b0, 8'h55});
        valid_cnt = 0; busy_max = 0; vt.delete();
        send_frame(8'h55, 1'b1, 2 * CPB, t0);
        idle(20);
        lat = (vt.size() > 0) ? vt[0] - t0 : -1;
        check("lat_55", 32'(lat >= 154 && lat <= 156), 32'd1);
        check("data_55", 32'(data), 32'h55);
        check("valid_cnt_55", 32'(valid_cnt), 32'd1);
        check("busy_run_55", 32'(busy_max >= 150 && busy_max <= 154), 32'd1);
        check("idle_busy_55", 32'(busy), 32'd0);

        exp_q.push_back({1'b0, 8'hA3});
        exp_q.push_back({1'b0, 8'h0F});
        valid_cnt = 0; vt.delete();
        send_frame(8'hA3, 1'b1, 2 * CPB, t0);
        send_frame(8'h0F, 1'b1, 2 * CPB, t1);
        idle(20);
        check("b2b_cnt", 32'(valid_cnt), 32'd2);
        check("b2b_gap", 32'((vt.size() == 2) ? vt[1] - vt[0] : -1), 32'd160);
        check("b2b_data", 32'(data), 32'h0F);

        exp_q.push_back({1'b1, 8'h0F});
        valid_cnt = 0; ferr_cnt = 0;
        send_frame(8'hFF, 1'b0, 2 * CPB, t0);
        rx = 1'b0;
        idle(40 * CPB);
        check("break_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(6);
        check("break_release", 32'(busy), 32'd0);
        check("break_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("break_valid_cnt", 32'(valid_cnt), 32'd0);
        check("break_data", 32'(data), 32'h0F);
        idle(10);

        valid_cnt = 0; ferr_cnt = 0; busy_max = 0;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(30);
        check("glitch_busy", 32'(busy_max >= 1 && busy_max <= 11), 32'd1);
        check("glitch_pulses", 32'(valid_cnt + ferr_cnt), 32'd0);
        check("glitch_idle", 32'(busy), 32'd0);

        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = (8'h3C >> i) & 1'b1;
            idle(CPB);
        end
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_data", 32'(data), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_valid", 32'(valid | frame_err), 32'd0);
        rx = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(10);
        valid_cnt = 0;
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1, 2 * CPB, t0);
        idle(20);
        check("after_rst_data", 32'(data), 32'hC3);
        check("after_rst_cnt", 32'(valid_cnt), 32'd1);

        valid_cnt = 0;
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1, 31, t0);
        idle(20);
        check("fast_data", 32'(data), 32'h81);
        check("fast_cnt", 32'(valid_cnt), 32'd1);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1, 33, t0);
        idle(20);
        check("slow_cnt", 32'(valid_cnt), 32'd2);
        check("slow_data", 32'(data), 32'h81);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
